div36x18s: RTL

DIV36X18S -- requirements
Module: div36x18s

---
 rtl/div36x18s_pkg.sv | 10 +
 rtl/div_restore_step.sv | 15 +
 rtl/div36x18s.sv | 86 ++++++++
 3 files changed

// File: rtl/div36x18s_pkg.sv
// div36x18s_pkg: widths, iteration count, range limits and FSM states for the 36/18 signed divider.
package div36x18s_pkg;
  localparam int DIVIDEND_W = 36;
  localparam int DIVISOR_W  = 18;
  localparam int QUOT_W     = 18;
  localparam int ITER       = 18;
  localparam logic [QUOT_W-1:0] QMAG_POS = 18'h1FFFF;
  localparam logic [QUOT_W-1:0] QMAG_NEG = 18'h20000;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring shift-subtract step producing the next partial remainder and a quotient bit.
module div_restore_step
  import div36x18s_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] div_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_o
);
  logic [DIVISOR_W:0] sh;
  assign sh    = {rem_i, bit_i};
  assign q_o   = sh >= {1'b0, div_i};
  assign rem_o = DIVISOR_W'(q_o ? sh - {1'b0, div_i} : sh);
endmodule

// File: rtl/div36x18s.sv
// div36x18s: sequential signed 36/18 divider, truncating toward zero, with overflow detection.
module div36x18s
  import div36x18s_pkg::*;
(
  input  logic                  C,
  input  logic                  R,
  input  logic                  CE,
  input  logic                  START,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  output logic [QUOT_W-1:0]     Q,
  output logic [DIVISOR_W-1:0]  REM,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF
);
  state_e                 state_q;
  logic [4:0]             cnt_q;
  logic [DIVISOR_W-1:0]   rem_q, div_q, lo_q, r_res_q, r_q;
  logic [QUOT_W-1:0]      quo_q, q_res_q, q_q;
  logic                   neg_q_q, neg_r_q, ovf_q, ovf_res_q, ovf_out_q, busy_q, done_q;
  logic [DIVIDEND_W:0]    a_ext, a_abs;
  logic [DIVISOR_W-1:0]   b_abs, rem_d;
  logic                   qbit_d, pre_ovf, ovf_any;
  assign a_ext   = {A[DIVIDEND_W-1], A};
  assign a_abs   = A[DIVIDEND_W-1] ? -a_ext : a_ext;
  assign b_abs   = B[DIVISOR_W-1] ? -B : B;
  // a quotient of 2^18 or more is already out of range, so the run is only kept for constant latency
  assign pre_ovf = (B == '0) || (a_abs[DIVIDEND_W:DIVISOR_W] >= {1'b0, b_abs});
  assign ovf_any = ovf_q | (neg_q_q ? quo_q > QMAG_NEG : quo_q > QMAG_POS);
  div_restore_step u_step (.rem_i(rem_q), .bit_i(lo_q[DIVISOR_W-1]), .div_i(div_q), .rem_o(rem_d), .q_o(qbit_d));
  always_ff @(posedge C) begin
    if (R) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (CE) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (START && !done_q) begin
          rem_q   <= a_abs[DIVIDEND_W-1:DIVISOR_W];
          lo_q    <= a_abs[DIVISOR_W-1:0];
          div_q   <= b_abs;
          quo_q   <= '0;
          neg_q_q <= A[DIVIDEND_W-1] ^ B[DIVISOR_W-1];
          neg_r_q <= A[DIVIDEND_W-1];
          ovf_q   <= pre_ovf;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_CALC;
        end
        S_CALC: begin
          rem_q   <= rem_d;
          lo_q    <= {lo_q[DIVISOR_W-2:0], 1'b0};
          quo_q   <= {quo_q[QUOT_W-2:0], qbit_d};
          cnt_q   <= cnt_q + 5'd1;
          state_q <= (cnt_q == 5'(ITER-1)) ? S_FIX : S_CALC;
        end
        S_FIX: begin
          q_res_q   <= ovf_any ? '0 : (neg_q_q ? -quo_q : quo_q);
          r_res_q   <= ovf_any ? '0 : (neg_r_q ? -rem_q : rem_q);
          ovf_res_q <= ovf_any;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          q_q       <= q_res_q;
          r_q       <= r_res_q;
          ovf_out_q <= ovf_res_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end
  assign Q    = q_q;
  assign REM  = r_q;
  assign OVF  = ovf_out_q;
  assign DONE = done_q;
  assign BUSY = busy_q;
endmodule
